mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral that answers the CPU's memory bus as a target device, the responder end of the bus the CPU drives as initiator. It decodes a 16-byte window of the address space and services reads and writes with the same one-cycle latency as data memory. It runs a prescaled up-counter against a compare value and raises a level interrupt for the control unit's exception path. Its `Dataout` is zero outside its window, so the top level can OR it with memory read data.

## Interface
- `BASE`, default 32'h0000_0100: window base address; must be 16-byte aligned.
- `PRESCALE`, default 4: clock cycles per count tick; legal range is 1 or more. With 1, the counter ticks every cycle.
- `Clk` input 1: system clock; all state changes on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Address` input 32: byte address from the CPU address mux.
- `Wr` input 1: write strobe; 1 = write, 0 = read.
- `Datain` input 32: write data, taken from the B register.
- `Dataout` output 32: registered read data; 0 when the previous cycle did not hit the window.
- `Hit` output 1: combinational; 1 when `Address[31:4] == BASE[31:4]`.
- `Irq` output 1: registered interrupt level; equals `STATUS.expired & CTRL.irq_en`.

## Operation
Register map, selected by `Address[3:2]`. `Address[1:0]` is ignored, so there are no misalignment faults.
- 0x0 `CTRL`, R/W:
  - bit0 `en`: counter runs while 1.
  - bit1 `reload`: on expiry, auto-reload instead of stopping.
  - bit2 `irq_en`: enables `Irq`.
  - bits 31:3 read as 0; writes to them are ignored.
- 0x4 `COMPARE`, R/W, 32 bits.
- 0x8 `COUNT`, R/W, 32 bits.
- 0xC `STATUS`, R/W1C:
  - bit0 `expired`.
  - writing 1 to bit0 clears it; writing 0 has no effect.
  - bits 31:1 read as 0.

Reset values:
- all registers 0, and the prescaler counter 0.
- outputs: `Dataout` = 0, `Irq` = 0.

Bus behaviour:
- **Write:** on a rising edge with `Hit=1` and `Wr=1`, the selected register updates.
- **Read:** on a rising edge with `Hit=1` and `Wr=0`, `Dataout` loads the selected register's pre-edge value.
- **No hit:** on any edge with `Hit=0`, `Dataout` loads 0.
- A write cycle loads `Dataout` with 0.

Counting:
- The prescaler `pc` is active while `en=1`. At `pc == PRESCALE-1` it produces a tick and wraps to 0; otherwise it increments by 1.
- When `en=0`, `pc` is held at 0.
- On a tick:
  - if `COUNT == COMPARE`: `expired` is set. If `reload=1`, `COUNT` goes to 0. If `reload=0`, `COUNT` holds and `en` is cleared.
  - otherwise `COUNT` increments by 1, modulo 2^32.
- Wrap-around: `COUNT` passes 0xFFFF_FFFF to 0 without expiring unless it equals `COMPARE`.
- With `COMPARE = 0` and `COUNT = 0`, the first tick expires.

Simultaneous events:
- A bus write to `COUNT` beats a tick increment or reload in the same cycle. The written value is what gets stored, and expiry is still evaluated on the pre-edge `COUNT`.
- A bus write to `CTRL` beats the auto-clear of `en`.
  - A write to `CTRL` with `en=0` zeroes `pc`.
  - A write to `CTRL` with `en=1` while already running leaves `pc` untouched.
- A W1C write to `STATUS` in the same cycle as an expiry leaves `expired = 1`; the set wins.
- `Reset` beats everything, including a bus write in the same cycle.

## Timing
- Read latency is 1 cycle: address is presented in cycle n and data is valid from the edge ending cycle n until the next edge. This matches the control unit's memory-wait state.
- A written value is visible to a read issued in the next cycle.
- `Irq` rises exactly 1 cycle after the edge that sets `expired`. It falls 1 cycle after the W1C edge, or after `irq_en` is cleared.
- Expiry period from enabling `CTRL` with `COUNT = 0` is `(COMPARE+1)*PRESCALE` cycles.
- Reset asserted mid-count: the next edge returns every register, `pc`, `Dataout` and `Irq` to 0. Any read that was in flight returns 0.

## Test plan
- **Reset and idle:** assert `Reset` for 2 cycles, then read each offset at `BASE`. `Dataout` = 0 and `Irq` = 0 throughout.
- **Read-back:** write `COMPARE` = 0xDEAD_BEEF, read 0x104, and expect 0xDEAD_BEEF one cycle later. Then write `CTRL` = 0xFFFF_FFFF; a read returns 0x7. A read at 0x200 returns 0 with `Hit` = 0.
- **One-shot:** `PRESCALE` = 4, `COMPARE` = 3, write `CTRL` = 0x5.
  - `STATUS.expired` = 1 at cycle 16 after the write.
  - `Irq` = 1 at cycle 17.
  - `CTRL.en` = 0 and `COUNT` stays at 3.
- **Auto-reload:** `COMPARE` = 2, `CTRL` = 0x7. Expiry fires every 12 cycles and `COUNT` returns to 0 each time. A W1C to 0x10C clears `Irq` on the next cycle.
- **Collisions:**
  - W1C on the same edge as an expiry: `expired` stays 1.
  - Write `COUNT` = 0x10 on a tick edge: `COUNT` = 0x10, not incremented.
  - `COUNT` = 0xFFFF_FFFF with `COMPARE` = 5: the next tick gives `COUNT` = 0 with no expiry.
- **Reset mid-operation:** assert `Reset` while running with `Irq` = 1. On the next edge all registers are 0, `Irq` = 0 and `Dataout` = 0.

Source files
------------

// File: rtl/mmio_timer_if.sv
// CPU data-bus connection for the memory-mapped timer: the CPU drives the
// address, strobe and write data; the timer returns read data and window hit.
interface mmio_timer_if;
    logic [31:0] Address;
    logic        Wr;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Hit;

    modport master (
        output Address,
        output Wr,
        output Datain,
        input  Dataout,
        input  Hit
    );

    modport slave (
        input  Address,
        input  Wr,
        input  Datain,
        output Dataout,
        output Hit
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled compare timer: CTRL/COMPARE/COUNT/STATUS in a 16-byte
// window, one-cycle registered reads, level interrupt on expiry.
module mmio_timer #(
    parameter logic [31:0] BASE     = 32'h0000_0100,
    parameter int unsigned PRESCALE = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    mmio_timer_if.slave  bus,
    output logic         Irq
);
    localparam logic [31:0] PC_LAST = 32'(PRESCALE - 1);

    logic        hit;
    logic [1:0]  sel;
    logic [3:0]  wr_sel;
    logic [31:0] rd_data;
    logic        tick;
    logic        fire;
    logic        unused_addr_bits;

    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dout_q, dout_d;
    logic        irq_q, irq_d;

    assign hit              = (bus.Address[31:4] == BASE[31:4]);
    assign sel              = bus.Address[3:2];
    assign unused_addr_bits = ^bus.Address[1:0];
    assign bus.Hit          = hit;
    assign bus.Dataout      = dout_q;
    assign Irq              = irq_q;

    // One write strobe per register slot
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr_dec
        assign wr_sel[gi] = hit & bus.Wr & (sel == 2'(gi));
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            2'd0: rd_data = {29'd0, irq_en_q, reload_q, en_q};
            2'd1: rd_data = compare_q;
            2'd2: rd_data = count_q;
            2'd3: rd_data = {31'd0, expired_q};
            default: rd_data = '0;
        endcase
    end

    assign tick = en_q & (pc_q == PC_LAST);
    assign fire = tick & (count_q == compare_q);

    // Bus writes are applied last so they override tick/reload/auto-stop effects
    always_comb begin
        en_d      = en_q;
        reload_d  = reload_q;
        irq_en_d  = irq_en_q;
        compare_d = compare_q;
        count_d   = count_q;
        pc_d      = (en_q && !tick) ? pc_q + 32'd1 : '0;

        if (tick) begin
            if (fire) begin
                if (reload_q) begin
                    count_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        expired_d = (expired_q & ~(wr_sel[3] & bus.Datain[0])) | fire;

        if (wr_sel[0]) begin
            en_d     = bus.Datain[0];
            reload_d = bus.Datain[1];
            irq_en_d = bus.Datain[2];
            if (!bus.Datain[0]) begin
                pc_d = '0;
            end
        end
        if (wr_sel[1]) begin
            compare_d = bus.Datain;
        end
        if (wr_sel[2]) begin
            count_d = bus.Datain;
        end

        dout_d = (hit && !bus.Wr) ? rd_data : '0;
        irq_d  = expired_q & irq_en_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            compare_q <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            pc_q      <= '0;
            dout_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            reload_q  <= reload_d;
            irq_en_q  <= irq_en_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            pc_q      <= pc_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus a random bus
// phase, every cycle compared against a register-level behavioural model.
module tb_mmio_timer;
    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam int unsigned PRESCALE = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Irq;

    always #5 Clk = ~Clk;

    mmio_timer_if bus_if();

    mmio_timer #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.slave),
        .Irq   (Irq)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Model state: the four architectural registers plus prescaler and outputs
    bit          m_en, m_reload, m_irqen, m_exp, m_irq;
    logic [31:0] m_cmp, m_cnt, m_dout;
    int unsigned m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] off);
        case (off)
            2'd0:    return {29'd0, m_irqen, m_reload, m_en};
            2'd1:    return m_cmp;
            2'd2:    return m_cnt;
            default: return {31'd0, m_exp};
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [31:0] a, input logic w,
                              input logic [31:0] d);
        bit          hit, tick, fire;
        logic [1:0]  off;
        logic [31:0] rdv;
        if (rst) begin
            m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0; m_irq = 0;
            m_cmp = 0; m_cnt = 0; m_dout = 0; m_pc = 0;
            return;
        end
        hit   = (a[31:4] == BASE[31:4]);
        off   = a[3:2];
        rdv   = m_reg(off);
        m_irq = m_exp && m_irqen;
        tick  = m_en && (m_pc == PRESCALE - 1);
        fire  = tick && (m_cnt == m_cmp);
        m_pc  = (m_en && !tick) ? m_pc + 1 : 0;
        if (tick) begin
            if (fire) begin
                m_exp = 1;
                if (m_reload) m_cnt = 0;
                else          m_en  = 0;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (hit && w) begin
            case (off)
                2'd0: begin
                    m_en = d[0]; m_reload = d[1]; m_irqen = d[2];
                    if (!d[0]) m_pc = 0;
                end
                2'd1: m_cmp = d;
                2'd2: m_cnt = d;
                default: if (d[0] && !fire) m_exp = 0;
            endcase
        end
        m_dout = (hit && !w) ? rdv : 32'd0;
    endtask

    task automatic cyc(input logic rst, input logic [31:0] a, input logic w, input logic [31:0] d);
        Reset          = rst;
        bus_if.Address = a;
        bus_if.Wr      = w;
        bus_if.Datain  = d;
        #1;
        chk("hit", 32'(bus_if.Hit), 32'(a[31:4] == BASE[31:4]));
        @(posedge Clk);
        model_edge(rst, a, w, d);
        #1;
        chk("dataout", bus_if.Dataout, m_dout);
        chk("irq", 32'(Irq), 32'(m_irq));
        txn++;
        $display("txn %0d rst=%0b addr=%08h wr=%0b din=%08h dout=%08h irq=%0b",
                 txn, rst, a, w, d, bus_if.Dataout, Irq);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, a, 1'b1, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, a, 1'b0, 32'd0);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0000_0200, 1'b0, 32'd0);
    endtask

    initial begin
        int          first_exp, first_irq, nrise, got_irq;
        int          rises[3];
        bit          irq_prev;
        logic [31:0] a, d;
        int          r;
        logic [1:0]  off;

        m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0; m_irq = 0;
        m_cmp = 0; m_cnt = 0; m_dout = 0; m_pc = 0;

        // Reset and idle
        cyc(1'b1, BASE, 1'b0, 32'd0);
        cyc(1'b1, BASE, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4 * i));
            chk("reset_reg", bus_if.Dataout, 32'd0);
            chk("reset_irq", 32'(Irq), 32'd0);
        end

        // Read-back
        wr(BASE + 32'h4, 32'hDEAD_BEEF);
        rd(BASE + 32'h4);
        chk("rb_compare", bus_if.Dataout, 32'hDEAD_BEEF);
        wr(BASE, 32'hFFFF_FFFF);
        rd(BASE);
        chk("rb_ctrl", bus_if.Dataout, 32'h0000_0007);
        wr(BASE, 32'd0);
        rd(32'h0000_0200);
        chk("rb_outside", bus_if.Dataout, 32'd0);
        chk("rb_outside_hit", 32'(bus_if.Hit), 32'd0);

        // One-shot: expiry edge is 16 cycles after the CTRL write; STATUS reads
        // show it one edge later (17), and Irq rises on that same edge
        wr(BASE + 32'h4, 32'd3);
        wr(BASE + 32'h8, 32'd0);
        wr(BASE + 32'hC, 32'd1);
        wr(BASE, 32'h5);
        first_exp = -1;
        first_irq = -1;
        for (int k = 1; k <= 20; k++) begin
            rd(BASE + 32'hC);
            if (first_exp < 0 && bus_if.Dataout[0]) first_exp = k;
            if (first_irq < 0 && Irq) first_irq = k;
        end
        chk("oneshot_expired_cycle", 32'(first_exp), 32'd17);
        chk("oneshot_irq_cycle", 32'(first_irq), 32'd17);
        rd(BASE);
        chk("oneshot_ctrl", bus_if.Dataout, 32'h4);
        rd(BASE + 32'h8);
        chk("oneshot_count", bus_if.Dataout, 32'd3);

        // Auto-reload: period (2+1)*4 = 12, Irq cleared by W1C
        wr(BASE + 32'hC, 32'd1);
        wr(BASE + 32'h4, 32'd2);
        wr(BASE + 32'h8, 32'd0);
        wr(BASE, 32'h7);
        irq_prev = Irq;
        nrise = 0;
        for (int k = 1; k <= 40; k++) begin
            if (irq_prev) wr(BASE + 32'hC, 32'd1);
            else          rd(BASE + 32'h8);
            if (Irq && !irq_prev) begin
                if (nrise < 3) rises[nrise] = k;
                nrise++;
                chk("reload_count_zero", bus_if.Dataout, 32'd0);
            end
            irq_prev = Irq;
        end
        chk("reload_rises", 32'(nrise), 32'd3);
        chk("reload_first", 32'(rises[0]), 32'd13);
        chk("reload_period1", 32'(rises[1] - rises[0]), 32'd12);
        chk("reload_period2", 32'(rises[2] - rises[1]), 32'd12);

        // Collision: W1C on the expiry edge
        wr(BASE, 32'd0);
        wr(BASE + 32'hC, 32'd1);
        wr(BASE + 32'h4, 32'd0);
        wr(BASE + 32'h8, 32'd0);
        wr(BASE, 32'h5);
        idle(); idle(); idle();
        wr(BASE + 32'hC, 32'd1);
        rd(BASE + 32'hC);
        chk("w1c_vs_expiry", bus_if.Dataout, 32'd1);

        // Collision: COUNT write on a tick edge
        wr(BASE + 32'hC, 32'd1);
        wr(BASE + 32'h4, 32'd100);
        wr(BASE + 32'h8, 32'd0);
        wr(BASE, 32'h1);
        idle(); idle(); idle();
        wr(BASE + 32'h8, 32'h10);
        rd(BASE + 32'h8);
        chk("count_write_vs_tick", bus_if.Dataout, 32'h10);

        // Wrap-around without expiry
        wr(BASE, 32'd0);
        wr(BASE + 32'h4, 32'd5);
        wr(BASE + 32'h8, 32'hFFFF_FFFF);
        wr(BASE, 32'h1);
        idle(); idle(); idle(); idle();
        rd(BASE + 32'h8);
        chk("wrap_count", bus_if.Dataout, 32'd0);
        rd(BASE + 32'hC);
        chk("wrap_no_expiry", bus_if.Dataout, 32'd0);

        // Reset while running with Irq high; reset beats a same-cycle write
        wr(BASE, 32'd0);
        wr(BASE + 32'h4, 32'd0);
        wr(BASE + 32'h8, 32'd0);
        wr(BASE, 32'h7);
        got_irq = 0;
        for (int k = 0; k < 20 && !got_irq; k++) begin
            idle();
            if (Irq) got_irq = 1;
        end
        chk("pre_reset_irq", 32'(got_irq), 32'd1);
        cyc(1'b1, BASE + 32'h8, 1'b0, 32'd0);
        chk("reset_inflight_read", bus_if.Dataout, 32'd0);
        chk("reset_irq_low", 32'(Irq), 32'd0);
        cyc(1'b1, BASE, 1'b1, 32'h7);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4 * i));
            chk("post_reset_reg", bus_if.Dataout, 32'd0);
        end

        // Random bus traffic against the model
        for (int n = 0; n < 600; n++) begin
            r   = int'($urandom_range(0, 99));
            off = 2'($urandom_range(0, 3));
            a   = BASE | {28'd0, off, 2'($urandom_range(0, 3))};
            if (off == 2'd1)      d = 32'($urandom_range(0, 12));
            else if (off == 2'd2) d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                                  : 32'($urandom_range(0, 12));
            else                  d = $urandom;
            if (r < 1) begin
                cyc(1'b1, a, 1'($urandom_range(0, 1)), d);
            end else if (r < 11) begin
                a = $urandom;
                if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
                cyc(1'b0, a, 1'($urandom_range(0, 1)), d);
            end else if (r < 30) begin
                wr(a, d);
            end else begin
                rd(a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
